// File: rtl/uart_rx_pkg.sv
// Shared types and register map for the memory-mapped UART receiver.
package uart_rx_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} rx_state_e;

  localparam logic [31:0] DATA_OFS   = 32'd0;
  localparam logic [31:0] STATUS_OFS = 32'd4;

  localparam int ST_VALID   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVR     = 2;
  localparam int ST_FERR    = 3;
  localparam int ST_PERR    = 4;
  localparam int ST_CNT_LSB = 8;
  localparam int ST_CNT_W   = 5;
endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO with first-word-fall-through head; a push while full is accepted only alongside a pop.
module uart_rx_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/uart_rx_mmio.sv
// Memory-mapped UART receiver: synchronizer, receive FSM, byte FIFO and DATA/STATUS registers.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity check; default is 8N1.
module uart_rx_mmio
  import uart_rx_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 651,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Rx,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  output logic [31:0] RdData,
  output logic        Hit,
  output logic        Irq
);
  localparam int BCW = $clog2(CLKS_PER_BIT);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] HALF_LAST = BCW'(CLKS_PER_BIT / 2 - 1);

  logic            rx_s1, rx_s2;
  rx_state_e       state, state_n;
  logic [BCW-1:0]  baud, baud_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic [7:0]      shreg, shreg_n;
  logic            push_req, ferr_set;
  logic [7:0]      head;
  logic            full, empty, pop;
  logic [CW-1:0]   count;
  logic            hit_data, hit_stat, wr_stat;
  logic            ovr, ferr;
  logic [31:0]     status;
  logic            unused_bits;
`ifdef UART_RX_PARITY_EN
  logic            par_bad, par_bad_n, perr_set, perr;
`endif

  assign unused_bits = ^WrData;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= Rx;
      rx_s2 <= rx_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
`ifdef UART_RX_PARITY_EN
      par_bad <= par_bad_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    baud_n    = baud + 1'b1;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    push_req  = 1'b0;
    ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad;
    perr_set  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        baud_n = '0;
        if (!rx_s2) state_n = S_START;
      end
      // Half-bit resample rejects glitches shorter than half a bit.
      S_START: if (baud == HALF_LAST) begin
        baud_n    = '0;
        bit_idx_n = '0;
        state_n   = rx_s2 ? S_IDLE : S_DATA;
      end
      S_DATA: if (baud == BIT_LAST) begin
        baud_n    = '0;
        shreg_n   = {rx_s2, shreg[7:1]};
        bit_idx_n = bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
        if (bit_idx == 3'd7) state_n = S_PARITY;
`else
        if (bit_idx == 3'd7) state_n = S_STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (baud == BIT_LAST) begin
        baud_n    = '0;
        par_bad_n = rx_s2 ^ (^shreg);
        perr_set  = par_bad_n;
        state_n   = S_STOP;
      end
`endif
      S_STOP: if (baud == BIT_LAST) begin
        state_n = S_IDLE;
`ifdef UART_RX_PARITY_EN
        if (rx_s2) push_req = !par_bad;
`else
        if (rx_s2) push_req = 1'b1;
`endif
        else       ferr_set = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .din   (shreg),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign hit_data = (Addr == BASE_ADDR + DATA_OFS);
  assign hit_stat = (Addr == BASE_ADDR + STATUS_OFS);
  assign Hit      = hit_data || hit_stat;
  assign pop      = MemRd && hit_data && !empty;
  assign wr_stat  = MemWr && hit_stat;

  // Sticky flags: set takes priority over a same-cycle write-1-to-clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
      Irq  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr <= 1'b0;
`endif
    end else begin
      ovr  <= (push_req && full && !pop) || (ovr && !(wr_stat && WrData[ST_OVR]));
      ferr <= ferr_set || (ferr && !(wr_stat && WrData[ST_FERR]));
      Irq  <= !empty;
`ifdef UART_RX_PARITY_EN
      perr <= perr_set || (perr && !(wr_stat && WrData[ST_PERR]));
`endif
    end
  end

  always_comb begin
    status           = '0;
    status[ST_VALID] = !empty;
    status[ST_FULL]  = full;
    status[ST_OVR]   = ovr;
    status[ST_FERR]  = ferr;
`ifdef UART_RX_PARITY_EN
    status[ST_PERR]  = perr;
`endif
    status[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(count);
  end

  always_comb begin
    RdData = '0;
    if (hit_data)      RdData = empty ? 32'd0 : {24'd0, head};
    else if (hit_stat) RdData = status;
  end
endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed + randomized bench for uart_rx_mmio against a queue-based model of the FIFO and flags.
module tb_uart_rx_mmio;
  localparam int CPB   = 16;
  localparam int DEPTH = 8;
  localparam logic [31:0] BASE   = 32'h4000_0020;
  localparam logic [31:0] DATA_A = BASE;
  localparam logic [31:0] STAT_A = BASE + 32'd4;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 10;
`else
  localparam int NBITS = 9;
`endif
  // Stop bit is sampled mid-bit, two synchronizer cycles plus one detect cycle after the line moves.
  localparam int STOP_EDGE = 3 + CPB / 2 + NBITS * CPB;

  logic        clk = 1'b0, rst = 1'b0, Rx = 1'b1, MemRd = 1'b0, MemWr = 1'b0;
  logic [31:0] Addr = '0, WrData = '0, RdData;
  logic        Hit, Irq;

  uart_rx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .Rx(Rx), .MemRd(MemRd), .MemWr(MemWr),
    .Addr(Addr), .WrData(WrData), .RdData(RdData), .Hit(Hit), .Irq(Irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  byte unsigned q[$];
  bit m_ovr = 0, m_ferr = 0, m_perr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[0]    = q.size() != 0;
    s[1]    = q.size() == DEPTH;
    s[2]    = m_ovr;
    s[3]    = m_ferr;
    s[4]    = m_perr;
    s[12:8] = 5'(q.size());
    return s;
  endfunction

  task automatic line(input bit v);
    Rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
    line(1'b0);
    for (int i = 0; i < 8; i++) line(b[i]);
`ifdef UART_RX_PARITY_EN
    line((^b) ^ !par_ok);
`endif
    line(stop_ok);
    Rx = 1'b1;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
    bit pok;
    pok = 1'b1;
`ifdef UART_RX_PARITY_EN
    pok = par_ok;
    if (!par_ok) m_perr = 1;
`endif
    if (!stop_ok) m_ferr = 1;
    else if (pok) begin
      if (q.size() == DEPTH) m_ovr = 1;
      else q.push_back(b);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok, input bit par_ok);
    frame(b, stop_ok, par_ok);
    model_frame(b, stop_ok, par_ok);
    repeat (4) @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    Addr = a; MemRd = 1'b1;
    #1 d = RdData;
    @(negedge clk);
    MemRd = 1'b0; Addr = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    Addr = a; WrData = v; MemWr = 1'b1;
    @(negedge clk);
    MemWr = 1'b0; Addr = '0; WrData = '0;
  endtask

  task automatic rd_data_chk(input string tag);
    logic [31:0] d, e;
    e = '0;
    if (q.size() != 0) e = {24'd0, q.pop_front()};
    rd(DATA_A, d);
    chk(tag, d, e);
  endtask

  task automatic status_chk(input string tag);
    logic [31:0] d;
    rd(STAT_A, d);
    chk(tag, d, exp_status());
    chk({tag, "_irq"}, {31'd0, Irq}, {31'd0, q.size() != 0});
  endtask

  task automatic hit_chk(input string tag, input logic [31:0] a, input bit exp_hit);
    @(negedge clk);
    Addr = a;
    #1;
    chk({tag, "_hit"}, {31'd0, Hit}, {31'd0, exp_hit});
    if (!exp_hit) chk({tag, "_rd0"}, RdData, 32'd0);
    Addr = '0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, d5, e5;
    logic [7:0]  b;
    bit          sok, pok;

    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_irq", {31'd0, Irq}, 32'd0);
    status_chk("reset_status");
    hit_chk("map_data", DATA_A, 1'b1);
    hit_chk("map_stat", STAT_A, 1'b1);
    hit_chk("map_plus8", BASE + 32'd8, 1'b0);
    hit_chk("map_minus4", BASE - 32'd4, 1'b0);

    // Single byte
    send(8'hA5, 1'b1, 1'b1);
    rd(STAT_A, d); chk("t1_status", d, 32'h0000_0101);
    chk("t1_irq", {31'd0, Irq}, 32'd1);
    rd_data_chk("t1_data");
    status_chk("t1_after");
    chk("t1_after_const", exp_status(), 32'd0);

    // Overrun on ninth byte
    for (int i = 1; i <= 9; i++) send(8'(i), 1'b1, 1'b1);
    rd(STAT_A, d); chk("t2_full_status", d, 32'h0000_0807);
    for (int i = 0; i < 8; i++) rd_data_chk($sformatf("t2_data%0d", i));
    rd(STAT_A, d); chk("t2_ovr_only", d, 32'h0000_0004);
    rd_data_chk("t2_empty_read");
    status_chk("t2_empty_nochg");
    wr(DATA_A, 32'hFFFF_FFFF);
    status_chk("t2_data_write_ignored");
    wr(STAT_A, 32'h4); m_ovr = 0;
    status_chk("t2_w1c_ovr");

    // Framing error
    send(8'h3C, 1'b0, 1'b1);
    rd(STAT_A, d); chk("t3_ferr", d, 32'h0000_0008);
    wr(STAT_A, 32'h8); m_ferr = 0;
    status_chk("t3_w1c_ferr");

    // Short start glitch
    Rx = 1'b0; repeat (4) @(negedge clk);
    Rx = 1'b1; repeat (3 * CPB) @(negedge clk);
    status_chk("t4_glitch");
    send(8'h96, 1'b1, 1'b1);
    rd_data_chk("t4_after_glitch");

    // Pop coincides with push into a full FIFO
    for (int i = 0; i < DEPTH; i++) send(8'($urandom), 1'b1, 1'b1);
    e5 = {24'd0, q[0]};
    fork
      frame(8'h77, 1'b1, 1'b1);
      begin
        repeat (STOP_EDGE - 1) @(posedge clk);
        @(negedge clk);
        Addr = DATA_A; MemRd = 1'b1;
        #1 d5 = RdData;
        @(negedge clk);
        MemRd = 1'b0; Addr = '0;
        void'(q.pop_front());
      end
    join
    model_frame(8'h77, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    chk("t5_pop_val", d5, e5);
    rd(STAT_A, d); chk("t5_status", d, 32'h0000_0803);
    for (int i = 0; i < DEPTH; i++) rd_data_chk($sformatf("t5_drain%0d", i));
    status_chk("t5_empty");

    // Reset in the middle of a data bit
    line(1'b0); line(1'b1); line(1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b0; Rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    q.delete(); m_ovr = 0; m_ferr = 0; m_perr = 0;
    repeat (CPB) @(negedge clk);
    status_chk("t6_after_reset");
    send(8'h5A, 1'b1, 1'b1);
    rd(STAT_A, d); chk("t6_one_byte", d, 32'h0000_0101);
    rd_data_chk("t6_data");
`ifdef UART_RX_PARITY_EN
    send(8'h5A, 1'b1, 1'b0);
    rd(STAT_A, d); chk("t6_parity_err", d, 32'h0000_0010);
    wr(STAT_A, 32'h10); m_perr = 0;
    status_chk("t6_w1c_perr");
`endif

    // Randomized frames, reads and clears
    for (int it = 0; it < 16; it++) begin
      b   = 8'($urandom);
      sok = $urandom_range(0, 4) != 0;
      pok = $urandom_range(0, 4) != 0;
      send(b, sok, pok);
      for (int r = 0, nr = $urandom_range(0, 2); r < nr; r++)
        rd_data_chk($sformatf("rnd%0d_data%0d", it, r));
      status_chk($sformatf("rnd%0d_status", it));
      if ($urandom_range(0, 3) == 0) begin
        d = 32'($urandom_range(0, 7)) << 2;
        wr(STAT_A, d);
        if (d[2]) m_ovr = 0;
        if (d[3]) m_ferr = 0;
        if (d[4]) m_perr = 0;
      end
    end
    while (q.size() != 0) rd_data_chk("rnd_drain");
    status_chk("rnd_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
